// File: rtl/snake_pixel_renderer.sv
// Two-stage pixel renderer for the snake game: stage 1 registers layer hits and
// the infobar ROM address, stage 2 merges them with ROM data by layer priority.
module snake_pixel_renderer #(
  parameter int COORD_W      = 11,
  parameter int MAX_LEN      = 23,
  parameter int LEN_W        = 6,
  parameter int NUM_APPLES   = 1,
  parameter int BLK_SIZE     = 32,
  parameter int H_ACTIVE     = 1440,
  parameter int V_ACTIVE     = 900,
  parameter int BORDER       = 16,
  parameter int INFO_X0      = 16,
  parameter int INFO_Y0      = 16,
  parameter int INFO_W       = 1408,
  parameter int INFO_H       = 128,
  parameter int ADDR_W       = 18,
  parameter int FLASH_FRAMES = 30
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  input  logic [COORD_W-1:0]            curr_x,
  input  logic [COORD_W-1:0]            curr_y,
  input  logic [MAX_LEN*COORD_W-1:0]    snakepos_x,
  input  logic [MAX_LEN*COORD_W-1:0]    snakepos_y,
  input  logic [LEN_W-1:0]              length,
  input  logic [NUM_APPLES*COORD_W-1:0] applepos_x,
  input  logic [NUM_APPLES*COORD_W-1:0] applepos_y,
  input  logic [NUM_APPLES-1:0]         apple_en,
  input  logic                          win,
  input  logic                          lose,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [11:0]                   rom_pixel,
  output logic [3:0]                    draw_r,
  output logic [3:0]                    draw_g,
  output logic [3:0]                    draw_b,
  output logic                          draw_valid
);

  localparam logic [COORD_W:0] C_BLK = (COORD_W+1)'(BLK_SIZE);
  localparam logic [COORD_W:0] C_IX0 = (COORD_W+1)'(INFO_X0);
  localparam logic [COORD_W:0] C_IX1 = (COORD_W+1)'(INFO_X0 + INFO_W);
  localparam logic [COORD_W:0] C_IY0 = (COORD_W+1)'(INFO_Y0);
  localparam logic [COORD_W:0] C_IY1 = (COORD_W+1)'(INFO_Y0 + INFO_H);
  localparam logic [COORD_W:0] C_BLO = (COORD_W+1)'(BORDER);
  localparam logic [COORD_W:0] C_BXH = (COORD_W+1)'(H_ACTIVE - BORDER);
  localparam logic [COORD_W:0] C_BYH = (COORD_W+1)'(V_ACTIVE - BORDER);
  localparam logic [11:0]      RGB_BLACK = 12'h000;
  localparam logic [11:0]      RGB_RED   = 12'hF00;
  localparam logic [11:0]      RGB_GREEN = 12'h0F0;
  localparam logic [11:0]      RGB_WHITE = 12'hFFF;
  localparam int unsigned      CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((FLASH_FRAMES > 0) ? FLASH_FRAMES - 1 : 0);

  typedef enum logic {PH_OFF = 1'b0, PH_ON = 1'b1} phase_t;

  // Widened compare so pos+BLK_SIZE cannot wrap at the top of the coordinate range.
  function automatic logic f_in_blk(input logic [COORD_W-1:0] px, input logic [COORD_W-1:0] py,
                                    input logic [COORD_W-1:0] cx, input logic [COORD_W-1:0] cy);
    logic [COORD_W:0] ex;
    logic [COORD_W:0] ey;
    ex = {1'b0, px} + C_BLK;
    ey = {1'b0, py} + C_BLK;
    return ({1'b0, px} <= {1'b0, cx}) && ({1'b0, cx} < ex) &&
           ({1'b0, py} <= {1'b0, cy}) && ({1'b0, cy} < ey);
  endfunction

  logic [COORD_W:0]   w_x, w_y;
  logic [LEN_W-1:0]   w_len;
  logic               w_head, w_body, w_apple, w_info, w_border;
  logic [COORD_W-1:0] w_dx, w_dy;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_end, w_frame_start;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  phase_t             r_phase, w_phase_nxt;
  logic               r_valid, r_head, r_body, r_apple, r_info, r_border, r_end;
  logic [11:0]        r_end_rgb, w_rgb;

  assign w_x   = {1'b0, curr_x};
  assign w_y   = {1'b0, curr_y};
  assign w_len = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;

  always_comb begin
    w_head = (w_len != '0) && f_in_blk(snakepos_x[0 +: COORD_W], snakepos_y[0 +: COORD_W],
                                       curr_x, curr_y);
    w_body = 1'b0;
    for (int unsigned i = 1; i < MAX_LEN; i++) begin
      if ((i < 32'(w_len)) && f_in_blk(snakepos_x[i*COORD_W +: COORD_W],
                                       snakepos_y[i*COORD_W +: COORD_W], curr_x, curr_y))
        w_body = 1'b1;
    end
    w_apple = 1'b0;
    for (int unsigned k = 0; k < NUM_APPLES; k++) begin
      if (apple_en[k] && f_in_blk(applepos_x[k*COORD_W +: COORD_W],
                                  applepos_y[k*COORD_W +: COORD_W], curr_x, curr_y))
        w_apple = 1'b1;
    end
  end

  assign w_info   = (w_x >= C_IX0) && (w_x < C_IX1) && (w_y >= C_IY0) && (w_y < C_IY1);
  assign w_border = (w_x < C_BLO) || (w_x >= C_BXH) || (w_y < C_BLO) || (w_y >= C_BYH);
  assign w_dx     = curr_x - COORD_W'(INFO_X0);
  assign w_dy     = curr_y - COORD_W'(INFO_Y0);
  assign w_addr   = ADDR_W'(w_dy) * ADDR_W'(INFO_W) + ADDR_W'(w_dx);

  assign w_end         = win | lose;
  assign w_frame_start = pix_valid && (curr_x == '0) && (curr_y == '0);

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (!w_end || (FLASH_FRAMES == 0)) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = PH_ON;
    end else if (w_frame_start) begin
      if (r_cnt == C_CNT_LAST) begin
        w_cnt_nxt   = '0;
        w_phase_nxt = (r_phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_phase <= PH_ON;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Stage 1: the end-screen colour is resolved here using the phase seen by this pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid   <= 1'b0;
      r_head    <= 1'b0;
      r_body    <= 1'b0;
      r_apple   <= 1'b0;
      r_info    <= 1'b0;
      r_border  <= 1'b0;
      r_end     <= 1'b0;
      r_end_rgb <= '0;
      rom_addr  <= '0;
    end else begin
      r_valid   <= pix_valid;
      r_head    <= w_head;
      r_body    <= w_body;
      r_apple   <= w_apple;
      r_info    <= w_info;
      r_border  <= w_border;
      r_end     <= w_end;
      r_end_rgb <= (r_phase == PH_ON) ? (lose ? RGB_RED : RGB_GREEN) : RGB_BLACK;
      if (w_info)
        rom_addr <= w_addr;
    end
  end

  always_comb begin
    w_rgb = RGB_BLACK;
    if (!r_valid)                        w_rgb = RGB_BLACK;
    else if (r_end)                      w_rgb = r_end_rgb;
    else if (r_info && rom_pixel != '0)  w_rgb = rom_pixel;
    else if (r_head)                     w_rgb = RGB_RED;
    else if (r_body)                     w_rgb = RGB_GREEN;
    else if (r_apple || r_border)        w_rgb = RGB_WHITE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      draw_r     <= '0;
      draw_g     <= '0;
      draw_b     <= '0;
      draw_valid <= 1'b0;
    end else begin
      draw_r     <= w_rgb[11:8];
      draw_g     <= w_rgb[7:4];
      draw_b     <= w_rgb[3:0];
      draw_valid <= r_valid;
    end
  end

endmodule

// File: tb/tb_snake_pixel_renderer.sv
// Bench for snake_pixel_renderer: directed vector table, flash/reset/latency
// sequences, and randomized scenes checked against a rule-level model.
module tb_snake_pixel_renderer;

  localparam int W  = 11;
  localparam int ML = 23;
  localparam int LW = 6;
  localparam int NA = 1;
  localparam int AW = 18;
  localparam int FF = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid;
  logic [W-1:0]      curr_x, curr_y;
  logic [ML*W-1:0]   snakepos_x, snakepos_y;
  logic [LW-1:0]     length;
  logic [NA*W-1:0]   applepos_x, applepos_y;
  logic [NA-1:0]     apple_en;
  logic              win, lose;
  logic [AW-1:0]     rom_addr;
  logic [11:0]       rom_pixel;
  logic [3:0]        draw_r, draw_g, draw_b;
  logic              draw_valid;

  int sx[ML];
  int sy[ML];
  int ax, ay;
  int rom_mode, rom_mode_d;

  always #5 clk = ~clk;

  snake_pixel_renderer #(.FLASH_FRAMES(FF)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .curr_x(curr_x), .curr_y(curr_y),
    .snakepos_x(snakepos_x), .snakepos_y(snakepos_y), .length(length),
    .applepos_x(applepos_x), .applepos_y(applepos_y), .apple_en(apple_en),
    .win(win), .lose(lose), .rom_addr(rom_addr), .rom_pixel(rom_pixel),
    .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b), .draw_valid(draw_valid)
  );

  always_comb begin
    snakepos_x = '0;
    snakepos_y = '0;
    for (int i = 0; i < ML; i++) begin
      snakepos_x[i*W +: W] = W'(sx[i]);
      snakepos_y[i*W +: W] = W'(sy[i]);
    end
    applepos_x = W'(ax);
    applepos_y = W'(ay);
  end

  function automatic logic [11:0] rom_val(input int mode, input logic [AW-1:0] a);
    case (mode)
      1:       return 12'h000;
      2:       return 12'hABC;
      default: return (a[2:0] == 3'd0) ? 12'h000 : a[11:0];
    endcase
  endfunction

  // ROM model: data follows the address by one cycle, content mode delayed to match.
  always @(posedge clk) rom_mode_d <= rom_mode;
  always_comb rom_pixel = rom_val(rom_mode_d, rom_addr);

  typedef struct { logic v; logic [11:0] rgb; } exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  int m_addr = 0;
  int m_fs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_blk(input int px, input int py, input int x, input int y);
    return (x >= px) && (x < px + 32) && (y >= py) && (y < py + 32);
  endfunction

  function automatic bit in_info(input int x, input int y);
    return (x >= 16) && (x < 16 + 1408) && (y >= 16) && (y < 16 + 128);
  endfunction

  function automatic int info_addr(input int x, input int y);
    return (y - 16) * 1408 + (x - 16);
  endfunction

  function automatic logic [11:0] model_rgb(input logic v, input int x, input int y);
    int le;
    logic [11:0] rv;
    if (!v) return 12'h000;
    if (win || lose) begin
      if (((m_fs / FF) % 2) != 0) return 12'h000;
      return lose ? 12'hF00 : 12'h0F0;
    end
    if (in_info(x, y)) begin
      rv = rom_val(rom_mode, AW'(info_addr(x, y)));
      if (rv != 12'h000) return rv;
    end
    le = (int'(length) > ML) ? ML : int'(length);
    if (le >= 1 && in_blk(sx[0], sy[0], x, y)) return 12'hF00;
    for (int i = 1; i < le; i++)
      if (in_blk(sx[i], sy[i], x, y)) return 12'h0F0;
    if (apple_en[0] && in_blk(ax, ay, x, y)) return 12'hFFF;
    if (x < 16 || x >= 1440 - 16 || y < 16 || y >= 900 - 16) return 12'hFFF;
    return 12'h000;
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("rgb", {20'd0, draw_r, draw_g, draw_b}, {20'd0, e.rgb});
      chk("draw_valid", {31'd0, draw_valid}, {31'd0, e.v});
    end
    chk("rom_addr", {14'd0, rom_addr}, m_addr);
  endtask

  task automatic push(input logic v, input int x, input int y, input logic use_model,
                      input logic [11:0] exp);
    exp_t e;
    pix_valid = v;
    curr_x    = W'(x);
    curr_y    = W'(y);
    e.v   = v;
    e.rgb = use_model ? model_rgb(v, x, y) : exp;
    q.push_back(e);
    if (in_info(x, y)) m_addr = info_addr(x, y);
    if (!(win || lose)) m_fs = 0;
    else if (v && x == 0 && y == 0) m_fs++;
  endtask

  task automatic set_scene(input int hx, input int hy, input int len, input int ax_,
                           input int ay_, input logic aen);
    for (int i = 0; i < ML; i++) begin
      sx[i] = hx + 32 * i;
      sy[i] = hy;
    end
    length   = LW'(len);
    ax       = ax_;
    ay       = ay_;
    apple_en = aen;
  endtask

  task automatic step(input logic w, input logic l, input int x, input int y,
                      input logic [11:0] exp);
    tick();
    win  = w;
    lose = l;
    push(1'b1, x, y, 1'b0, exp);
  endtask

  typedef struct {
    logic v; int x; int y; int hx; int hy; int len; int ax; int ay;
    logic aen; int rom; logic [11:0] exp;
  } tv_t;
  tv_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{1'b1,  100, 200,  100, 200,  3, 300, 300, 1'b0, 0, 12'hF00});
    tbl.push_back('{1'b1,  131, 231,  100, 200,  3, 300, 300, 1'b0, 0, 12'hF00});
    tbl.push_back('{1'b1,  132, 200,  100, 200,  3, 300, 300, 1'b0, 0, 12'h0F0});
    tbl.push_back('{1'b1,  196, 200,  100, 200,  3, 300, 300, 1'b0, 0, 12'h000});
    tbl.push_back('{1'b1,  164, 200,  100, 200,  2, 300, 300, 1'b0, 0, 12'h000});
    tbl.push_back('{1'b1,  195, 231,  100, 200,  3, 300, 300, 1'b0, 0, 12'h0F0});
    tbl.push_back('{1'b1,  132, 232,  100, 200,  3, 300, 300, 1'b0, 0, 12'h000});
    tbl.push_back('{1'b1,  300, 300,  300, 300,  1, 300, 300, 1'b1, 0, 12'hF00});
    tbl.push_back('{1'b1,  300, 300,  100, 200,  3, 300, 300, 1'b0, 0, 12'h000});
    tbl.push_back('{1'b1,  300, 300,  100, 200,  3, 300, 300, 1'b1, 0, 12'hFFF});
    tbl.push_back('{1'b1,  331, 331,  100, 200,  3, 300, 300, 1'b1, 0, 12'hFFF});
    tbl.push_back('{1'b1,  332, 300,  100, 200,  3, 300, 300, 1'b1, 0, 12'h000});
    tbl.push_back('{1'b1,    5, 500,  100, 200,  3, 300, 300, 1'b0, 0, 12'hFFF});
    tbl.push_back('{1'b1, 1424, 500,  100, 200,  3, 300, 300, 1'b0, 0, 12'hFFF});
    tbl.push_back('{1'b1, 1423, 500,  100, 200,  3, 300, 300, 1'b0, 0, 12'h000});
    tbl.push_back('{1'b1,  700, 884,  100, 200,  3, 300, 300, 1'b0, 0, 12'hFFF});
    tbl.push_back('{1'b1,  700, 883,  100, 200,  3, 300, 300, 1'b0, 0, 12'h000});
    tbl.push_back('{1'b1,   16,  16,  100, 200,  3, 300, 300, 1'b0, 2, 12'hABC});
    tbl.push_back('{1'b1,   16,  16,   16,  16,  1, 300, 300, 1'b0, 1, 12'hF00});
    tbl.push_back('{1'b1,  500, 100,  100, 200,  3, 300, 300, 1'b0, 1, 12'h000});
    tbl.push_back('{1'b1,   15,  16,  100, 200,  3, 300, 300, 1'b0, 2, 12'hFFF});
    tbl.push_back('{1'b1, 1423,  50,  100, 200,  3, 300, 300, 1'b0, 2, 12'hABC});
    tbl.push_back('{1'b1,  500, 143,  100, 200,  3, 300, 300, 1'b0, 2, 12'hABC});
    tbl.push_back('{1'b1,  500, 144,  100, 200,  3, 300, 300, 1'b0, 2, 12'h000});
    tbl.push_back('{1'b1,  164, 200,  100, 200, 30, 300, 300, 1'b0, 0, 12'h0F0});
    tbl.push_back('{1'b1,  100, 200,  100, 200,  0, 300, 300, 1'b0, 0, 12'h000});
    tbl.push_back('{1'b0,  100, 200,  100, 200,  3, 300, 300, 1'b0, 0, 12'h000});
    tbl.push_back('{1'b1, 2040, 200, 2030, 200,  1, 300, 300, 1'b0, 0, 12'hF00});
    tbl.push_back('{1'b1, 2040,2040, 2030,2030,  1, 300, 300, 1'b0, 0, 12'hF00});

    rst = 1'b0; pix_valid = 1'b0; curr_x = '0; curr_y = '0;
    win = 1'b0; lose = 1'b0; rom_mode = 0;
    set_scene(100, 200, 3, 300, 300, 1'b0);
    repeat (3) @(negedge clk);
    chk("reset_rgb", {20'd0, draw_r, draw_g, draw_b}, 32'd0);
    chk("reset_valid", {31'd0, draw_valid}, 32'd0);
    chk("reset_rom_addr", {14'd0, rom_addr}, 32'd0);
    rst = 1'b1;

    foreach (tbl[n]) begin
      tick();
      set_scene(tbl[n].hx, tbl[n].hy, tbl[n].len, tbl[n].ax, tbl[n].ay, tbl[n].aen);
      rom_mode = tbl[n].rom;
      push(tbl[n].v, tbl[n].x, tbl[n].y, 1'b0, tbl[n].exp);
    end

    // Explicit infobar address values.
    tick();
    set_scene(100, 200, 3, 300, 300, 1'b0);
    rom_mode = 2;
    push(1'b1, 16, 16, 1'b0, 12'hABC);
    @(posedge clk); #1;
    chk("rom_addr_16_16", {14'd0, rom_addr}, 32'd0);
    tick();
    push(1'b1, 17, 17, 1'b0, 12'hABC);
    @(posedge clk); #1;
    chk("rom_addr_17_17", {14'd0, rom_addr}, 32'd1409);

    // Latency: valid pattern 1,0,1.
    tick(); rom_mode = 0; push(1'b1, 100, 200, 1'b0, 12'hF00);
    tick(); push(1'b0, 100, 200, 1'b0, 12'h000);
    tick(); push(1'b1, 100, 200, 1'b0, 12'hF00);

    // End-screen flashing with a 2-frame phase.
    step(1'b0, 1'b0,   0,   0, 12'hFFF);
    step(1'b1, 1'b1,  50, 500, 12'hF00);
    step(1'b1, 1'b1,   0,   0, 12'hF00);
    step(1'b1, 1'b1,  50, 500, 12'hF00);
    step(1'b1, 1'b1,   0,   0, 12'hF00);
    step(1'b1, 1'b1,  50, 500, 12'h000);
    step(1'b1, 1'b1,   0,   0, 12'h000);
    step(1'b1, 1'b1,  50, 500, 12'h000);
    step(1'b1, 1'b1,   0,   0, 12'h000);
    step(1'b1, 1'b1,  50, 500, 12'hF00);
    step(1'b1, 1'b0,  60, 600, 12'h0F0);
    step(1'b1, 1'b0,   0,   0, 12'h0F0);
    step(1'b1, 1'b0,  50, 500, 12'h0F0);
    step(1'b1, 1'b0,   0,   0, 12'h0F0);
    step(1'b1, 1'b0,  50, 500, 12'h000);
    step(1'b0, 1'b0, 100, 200, 12'hF00);
    step(1'b0, 1'b1,  50, 500, 12'hF00);
    step(1'b0, 1'b1,   0,   0, 12'hF00);
    step(1'b0, 1'b1,  50, 500, 12'hF00);
    step(1'b0, 1'b0,  50, 500, 12'h000);

    // Asynchronous reset mid-frame, away from any clock edge.
    tick(); win = 1'b0; lose = 1'b0; push(1'b1, 17, 17, 1'b1, 12'h000);
    tick(); push(1'b1, 100, 200, 1'b1, 12'h000);
    tick(); push(1'b1, 100, 200, 1'b1, 12'h000);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_rgb", {20'd0, draw_r, draw_g, draw_b}, 32'd0);
    chk("async_rst_valid", {31'd0, draw_valid}, 32'd0);
    chk("async_rst_rom_addr", {14'd0, rom_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    m_addr = 0;
    m_fs = 0;
    push(1'b1, 100, 200, 1'b1, 12'h000);
    tick(); push(1'b1, 132, 200, 1'b1, 12'h000);

    // Randomized scenes against the model.
    for (int n = 0; n < 600; n++) begin
      int r;
      tick();
      if (n % 16 == 0) begin
        for (int i = 0; i < ML; i++) begin
          sx[i] = $urandom_range(0, 480);
          sy[i] = $urandom_range(0, 480);
        end
        if (n % 64 == 0) begin
          sx[0] = $urandom_range(2000, 2047);
          sy[0] = $urandom_range(0, 480);
        end
        length   = LW'($urandom_range(0, 30));
        ax       = $urandom_range(0, 480);
        ay       = $urandom_range(0, 480);
        apple_en = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 15) == 0) win = ~win;
      if ($urandom_range(0, 15) == 0) lose = ~lose;
      r = $urandom_range(0, 9);
      if (r == 0)
        push($urandom_range(0, 7) != 0, 0, 0, 1'b1, 12'h000);
      else if (r == 1)
        push($urandom_range(0, 7) != 0, $urandom_range(1400, 2047), $urandom_range(0, 899),
             1'b1, 12'h000);
      else
        push($urandom_range(0, 7) != 0, $urandom_range(0, 511), $urandom_range(0, 511),
             1'b1, 12'h000);
    end

    repeat (2) begin
      tick();
      win = 1'b0;
      lose = 1'b0;
      push(1'b0, 700, 700, 1'b1, 12'h000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/snake_pixel_renderer.md
Name: snake_pixel_renderer

Overview:
- Parametrised, pipelined pixel renderer for the snake game. Successor to the current fixed-size draw controller.
- Takes the raster position from the VGA timing block plus game state from the snake/apple logic, and produces registered 12-bit RGB with a fixed 2-cycle latency.
- Generalised over snake length, block size, apple count, screen geometry and infobar placement.
- Adds address-computed infobar ROM fetch, a layer priority with transparency, and a flashing end screen.

Parameters:
- COORD_W, 11, width of every x/y coordinate.
- MAX_LEN, 23, maximum snake segments; segment 0 is the head.
- LEN_W, 6, width of length.
- NUM_APPLES, 1, number of apple slots.
- BLK_SIZE, 32, square size in pixels of segments and apples.
- H_ACTIVE, 1440, active width.
- V_ACTIVE, 900, active height.
- BORDER, 16, border thickness in pixels.
- INFO_X0, 16, infobar left edge.
- INFO_Y0, 16, infobar top edge.
- INFO_W, 1408, infobar width.
- INFO_H, 128, infobar height.
- ADDR_W, 18, ROM address width.
- FLASH_FRAMES, 30, frames per end-screen flash phase; 0 means solid, no flashing.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-low reset
- pix_valid  in  1  curr_x/curr_y are in the active area this cycle
- curr_x  in  COORD_W  raster x
- curr_y  in  COORD_W  raster y
- snakepos_x  in  MAX_LEN*COORD_W  segment i x at [i*COORD_W +: COORD_W]
- snakepos_y  in  MAX_LEN*COORD_W  segment i y
- length  in  LEN_W  live segment count
- applepos_x  in  NUM_APPLES*COORD_W  apple x per slot
- applepos_y  in  NUM_APPLES*COORD_W  apple y per slot
- apple_en  in  NUM_APPLES  slot enable
- win  in  1  win state
- lose  in  1  lose state
- rom_addr  out  ADDR_W  infobar ROM address (registered)
- rom_pixel  in  12  ROM data; valid 1 cycle after rom_addr
- draw_r  out  4  red
- draw_g  out  4  green
- draw_b  out  4  blue
- draw_valid  out  1  pix_valid delayed 2 cycles

Behaviour:
- Reset (rst=0, async): rom_addr=0, draw_r/g/b=0, draw_valid=0, flash counter=0, flash phase=on, all pipeline registers cleared.
- Stage 1 (cycle N), registered:
  - hit flags: head, body, apple, info, border.
  - rom_addr = (curr_y-INFO_Y0)*INFO_W + (curr_x-INFO_X0) when the pixel is inside the infobar, else holds its previous value.
  - pix_valid and the end state are registered alongside.
- Stage 2 (cycle N+1): combine flags with rom_pixel and register outputs. Outputs for the pixel at cycle N appear at N+2.
- Hit test, half-open rectangles:
  - segment/apple hit iff pos_x <= curr_x < pos_x+BLK_SIZE and pos_y <= curr_y < pos_y+BLK_SIZE.
  - Sums are computed at COORD_W+1 bits so they never wrap.
- Length handling:
  - head active iff length>=1.
  - body segment i (1..MAX_LEN-1) active iff i < length.
  - length > MAX_LEN is clamped to MAX_LEN.
- Apple slot k is active iff apple_en[k].
- info hit iff INFO_X0 <= x < INFO_X0+INFO_W and INFO_Y0 <= y < INFO_Y0+INFO_H.
- border hit iff x<BORDER, x>=H_ACTIVE-BORDER, y<BORDER, or y>=V_ACTIVE-BORDER.
- Colour priority, highest first:
  - end screen: lose -> F00, else win -> 0F0. lose dominates when both are set. Replaces everything.
  - info with rom_pixel != 000 -> rom_pixel. A rom_pixel of 000 is transparent and falls through.
  - head -> F00.
  - body -> 0F0.
  - apple -> FFF.
  - border -> FFF.
  - else 000.
- pix_valid=0 at stage 1 forces a 000 output at stage 2; draw_valid=0 for that pixel.
- Flash:
  - frame_start = pix_valid && curr_x==0 && curr_y==0.
  - While end state (win|lose) is active, the counter increments on each frame_start. On reaching FLASH_FRAMES-1 it wraps to 0 and toggles the phase.
  - Phase off renders the end screen as 000.
  - When the end state deasserts, counter=0 and phase=on, effective the next cycle.
  - FLASH_FRAMES=0: phase is held on.
- win/lose changing mid-frame take effect at the pixel sampled in stage 1; there is no frame buffering.

Test Plan:
- Reset: rst=0 asserted mid-frame -> draw_r/g/b=0, draw_valid=0 and rom_addr=0 immediately with no clock edge. Release, then 2 clocks later outputs track input.
- Snake: length=3, head (100,200), seg1 (132,200), seg2 (164,200). Pixel (100,200) -> F00 at N+2; (131,231) -> F00; (132,200) -> 0F0; (196,200) -> 000. With length=2, (164,200) -> 000.
- Overlap: head and apple both at (300,300) -> F00. Apple alone at (300,300) with apple_en=0 -> 000. Pixel (5,500) -> FFF border.
- Infobar: pixel (16,16) -> rom_addr=0. Pixel (17,17) -> rom_addr=1409. ROM returns ABC -> output ABC. ROM returns 000 over a head at (16,16) -> F00.
- End screen: lose=1, win=1, FLASH_FRAMES=2 -> red for frames 0-1, black for frames 2-3, red again. Deassert lose -> normal rendering next pixel, phase reset to on.
- Latency: pix_valid toggling 1,0,1 -> draw_valid 1,0,1 delayed exactly 2 cycles; the invalid slot outputs 000.
